// File: rtl/pipTypes.sv
// Types shared across the issue-queue pipeline. The buffer stores iq_entry_t
// by default. Slot indices are sized for the default queue depth.
package pipTypes;

   typedef struct packed {
      logic [7:0]  tag;
      logic [15:0] data;
   } iq_entry_t;

   localparam int IQ_DEPTH = 16;
   typedef logic [$clog2(IQ_DEPTH)-1:0] iq_slot_t;

endpackage

// File: rtl/tagged_circ_buf_pkg.sv
// Default geometry and small helpers for the tagged circular buffer.
package tagged_circ_buf_pkg;

   localparam int DEF_DEPTH        = 16;
   localparam int DEF_INS_COUNT    = 4;
   localparam int DEF_EXT_COUNT    = 4;
   localparam int DEF_AFULL_THRESH = 12;

   function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/tagged_circ_buf_if.sv
// Producer/consumer bundle for tagged_circ_buf. The master side drives
// requests. The slave side is the buffer.
interface tagged_circ_buf_if #(
   parameter type T         = pipTypes::iq_entry_t,
   parameter int  DEPTH     = tagged_circ_buf_pkg::DEF_DEPTH,
   parameter int  INS_COUNT = tagged_circ_buf_pkg::DEF_INS_COUNT,
   parameter int  EXT_COUNT = tagged_circ_buf_pkg::DEF_EXT_COUNT
);
   localparam int PW  = $clog2(DEPTH);
   localparam int ICW = $clog2(INS_COUNT + 1);
   localparam int ECW = $clog2(EXT_COUNT + 1);

   // Handshake: the producer offers ins_count lanes and the buffer answers
   // with ins_accepted in the same cycle. Lanes at or above ins_accepted
   // must be offered again. The consumer sees ext_valid[i] for each live
   // lane, and ext_count lanes leave at the edge. Over-requests are clipped.
   logic [ICW-1:0]       ins_count;
   T                     ins_elements [INS_COUNT];
   logic [ICW-1:0]       ins_accepted;
   logic [PW-1:0]        ins_slot     [INS_COUNT];
   logic [ECW-1:0]       ext_count;
   logic [EXT_COUNT-1:0] ext_valid;
   T                     ext_elements [EXT_COUNT];
   logic [PW-1:0]        ext_slot     [EXT_COUNT];
   logic                 flush;
   logic                 pflush;
   logic [PW-1:0]        pflush_slot;
   logic [PW:0]          used_count;
   logic [PW:0]          free_count;
   logic                 empty;
   logic                 full;
   logic                 almost_full;

   modport master (
      output ins_count, ins_elements, ext_count, flush, pflush, pflush_slot,
      input  ins_accepted, ins_slot, ext_valid, ext_elements, ext_slot,
             used_count, free_count, empty, full, almost_full
   );

   modport slave (
      input  ins_count, ins_elements, ext_count, flush, pflush, pflush_slot,
      output ins_accepted, ins_slot, ext_valid, ext_elements, ext_slot,
             used_count, free_count, empty, full, almost_full
   );

endinterface

// File: rtl/tagged_circ_buf.sv
// Multi-lane circular buffer with slot tags, supporting full and partial flush.
// Bit i of ext_valid corresponds to lane i, and lane 0 is the oldest entry.
module tagged_circ_buf
   import tagged_circ_buf_pkg::*;
#(
   parameter type T            = pipTypes::iq_entry_t,
   parameter int  DEPTH        = DEF_DEPTH,
   parameter int  INS_COUNT    = DEF_INS_COUNT,
   parameter int  EXT_COUNT    = DEF_EXT_COUNT,
   parameter int  AFULL_THRESH = DEF_AFULL_THRESH
) (
   input  logic             clock,
   input  logic             reset,
   tagged_circ_buf_if.slave bus
);
   localparam int PW  = $clog2(DEPTH);
   localparam int ICW = $clog2(INS_COUNT + 1);
   localparam int CW  = PW + 1;

   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] used_q;
   T              mem_q [DEPTH];

   logic [CW-1:0] free_w, ins_acc_w, ext_eff_w, used_n, pf_dist_w;
   logic [PW-1:0] head_n, tail_n, pf_dist;
   logic          pf_hit;

   always_comb begin
      free_w    = CW'(DEPTH) - used_q;
      ext_eff_w = CW'(min_u(32'(bus.ext_count), 32'(used_q)));
      ins_acc_w = (bus.flush || bus.pflush) ? '0
                  : CW'(min_u(32'(bus.ins_count), 32'(free_w)));

      // Distance from head to the pflush slot is the number of entries
      // older than that slot. Only a slot inside the live window counts.
      pf_dist   = bus.pflush_slot - head_q;
      pf_dist_w = {1'b0, pf_dist};
      pf_hit    = bus.pflush && (pf_dist_w < used_q);

      head_n = head_q + PW'(ext_eff_w);
      tail_n = tail_q + PW'(ins_acc_w);
      used_n = used_q + ins_acc_w - ext_eff_w;
      if (pf_hit) begin
         if (ext_eff_w > pf_dist_w) begin
            tail_n = head_n;
            used_n = '0;
         end else begin
            tail_n = bus.pflush_slot;
            used_n = pf_dist_w - ext_eff_w;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || bus.flush) begin
         head_q <= '0;
         tail_q <= '0;
         used_q <= '0;
      end else begin
         head_q <= head_n;
         tail_q <= tail_n;
         used_q <= used_n;
      end
   end

   // Storage is not reset. Only slots inside [head, head+used) are observable.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < INS_COUNT; i++) begin
            if (CW'(i) < ins_acc_w) mem_q[tail_q + PW'(i)] <= bus.ins_elements[i];
         end
      end
   end

   always_comb begin
      bus.ins_accepted = ICW'(ins_acc_w);
      bus.used_count   = used_q;
      bus.free_count   = free_w;
      bus.empty        = (used_q == '0);
      bus.full         = (used_q == CW'(DEPTH));
      bus.almost_full  = (used_q >= CW'(AFULL_THRESH));
      for (int i = 0; i < INS_COUNT; i++) begin
         bus.ins_slot[i] = tail_q + PW'(i);
      end
      for (int i = 0; i < EXT_COUNT; i++) begin
         bus.ext_slot[i]     = head_q + PW'(i);
         bus.ext_elements[i] = mem_q[head_q + PW'(i)];
         bus.ext_valid[i]    = (CW'(i) < used_q);
      end
   end

endmodule

// File: tb/tb_tagged_circ_buf.sv
// Self-checking bench for tagged_circ_buf. It uses a reference model, a
// scoreboard queue of live entries, and a vector table plus directed corners.
module tb_tagged_circ_buf;
   import pipTypes::*;
   import tagged_circ_buf_pkg::*;

   localparam int DEPTH = 16;
   localparam int INS   = 4;
   localparam int EXT   = 4;
   localparam int AFULL = 12;
   localparam int PW    = 4;
   localparam int ICW   = 3;
   localparam int ECW   = 3;
   localparam int W     = $bits(iq_entry_t);

   typedef struct {
      int ins_n;
      int ext_n;
      bit fl;
      int exp_acc;
      int exp_used;
   } vec_t;

   logic clock;
   logic reset;

   tagged_circ_buf_if #(.T(iq_entry_t), .DEPTH(DEPTH), .INS_COUNT(INS), .EXT_COUNT(EXT)) bus ();

   tagged_circ_buf #(
      .T(iq_entry_t), .DEPTH(DEPTH), .INS_COUNT(INS), .EXT_COUNT(EXT), .AFULL_THRESH(AFULL)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];
   int m_head = 0;
   int m_tail = 0;
   int m_used = 0;
   int acc;
   vec_t tbl[13];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // driver: one cycle of stimulus with model update and checks around the edge
   task automatic apply(input int ins_n, input int ext_n, input bit fl, input bit pf,
                        input int ps, input bit rs, output int acc_seen);
      int free, exp_acc, eff, d, nu;
      logic [W-1:0]   lane_data [INS];
      logic [W-1:0]   exp_e;
      logic [EXT-1:0] mask;
      @(negedge clock);
      reset           = rs;
      bus.flush       = fl;
      bus.pflush      = pf;
      bus.pflush_slot = PW'(ps);
      bus.ins_count   = ICW'(ins_n);
      bus.ext_count   = ECW'(ext_n);
      for (int i = 0; i < INS; i++) begin
         lane_data[i]        = W'($urandom);
         bus.ins_elements[i] = iq_entry_t'(lane_data[i]);
      end
      #1;
      acc_seen = int'(bus.ins_accepted);
      free     = DEPTH - m_used;
      exp_acc  = (fl || pf) ? 0 : ((ins_n < free) ? ins_n : free);
      eff      = (ext_n < m_used) ? ext_n : m_used;
      if (!rs) begin
         check("ins_accepted", acc_seen, exp_acc);
         for (int i = 0; i < INS; i++)
            check("ins_slot", int'(bus.ins_slot[i]), (m_tail + i) % DEPTH);
         for (int i = 0; i < EXT; i++) mask[i] = (i < m_used);
         check("ext_valid", int'(bus.ext_valid), int'(mask));
         for (int i = 0; i < EXT; i++)
            if (i < m_used) check("ext_slot", int'(bus.ext_slot[i]), (m_head + i) % DEPTH);
         if (!fl) begin
            for (int i = 0; i < eff; i++) begin
               exp_e = exp_q.pop_front();
               check("ext_data", int'(bus.ext_elements[i]), int'(exp_e));
            end
         end
      end
      @(posedge clock);
      if (rs || fl) begin
         m_head = 0;
         m_tail = 0;
         m_used = 0;
         exp_q.delete();
      end else if (pf) begin
         d = (ps - m_head) & (DEPTH - 1);
         if (d < m_used) begin
            nu = (d > eff) ? d - eff : 0;
            while (exp_q.size() > nu) void'(exp_q.pop_back());
            m_tail = (eff > d) ? (m_head + eff) % DEPTH : ps;
            m_used = nu;
         end else begin
            m_used = m_used - eff;
         end
         m_head = (m_head + eff) % DEPTH;
      end else begin
         for (int i = 0; i < exp_acc; i++) exp_q.push_back(lane_data[i]);
         m_head = (m_head + eff) % DEPTH;
         m_tail = (m_tail + exp_acc) % DEPTH;
         m_used = m_used + exp_acc - eff;
      end
      #1;
      check("used_count", int'(bus.used_count), m_used);
      check("free_count", int'(bus.free_count), DEPTH - m_used);
      check("empty", int'(bus.empty), int'(m_used == 0));
      check("full", int'(bus.full), int'(m_used == DEPTH));
      check("almost_full", int'(bus.almost_full), int'(m_used >= AFULL));
      check("head", int'(bus.ext_slot[0]), m_head);
      check("tail", int'(bus.ins_slot[0]), m_tail);
   endtask

   initial begin
      reset           = 1'b1;
      bus.flush       = 1'b0;
      bus.pflush      = 1'b0;
      bus.pflush_slot = '0;
      bus.ins_count   = '0;
      bus.ext_count   = '0;
      for (int i = 0; i < INS; i++) bus.ins_elements[i] = '0;

      apply(0, 0, 0, 0, 0, 1, acc);
      apply(0, 0, 0, 0, 0, 1, acc);
      check("rst_used", int'(bus.used_count), 0);
      check("rst_free", int'(bus.free_count), DEPTH);
      check("rst_empty", int'(bus.empty), 1);
      check("rst_valid", int'(bus.ext_valid), 0);

      // ins_n, ext_n, flush, expected accepted, expected used after edge
      tbl[0]  = '{4, 0, 0, 4, 4};
      tbl[1]  = '{4, 0, 0, 4, 8};
      tbl[2]  = '{4, 0, 0, 4, 12};
      tbl[3]  = '{4, 0, 0, 4, 16};
      tbl[4]  = '{4, 0, 0, 0, 16};
      tbl[5]  = '{0, 2, 0, 0, 14};
      tbl[6]  = '{4, 0, 0, 2, 16};
      tbl[7]  = '{4, 4, 0, 0, 12};
      tbl[8]  = '{3, 4, 0, 3, 11};
      tbl[9]  = '{0, 4, 0, 0, 7};
      tbl[10] = '{0, 4, 0, 0, 3};
      tbl[11] = '{1, 4, 0, 1, 1};
      tbl[12] = '{4, 4, 1, 0, 0};
      for (int k = 0; k < 13; k++) begin
         apply(tbl[k].ins_n, tbl[k].ext_n, tbl[k].fl, 0, 0, 0, acc);
         check($sformatf("tbl%0d_acc", k), acc, tbl[k].exp_acc);
         check($sformatf("tbl%0d_used", k), int'(bus.used_count), tbl[k].exp_used);
         if (k == 3) check("tbl_full_flag", int'(bus.full), 1);
      end

      // flush with work pending at used=9
      apply(4, 0, 0, 0, 0, 0, acc);
      apply(4, 0, 0, 0, 0, 0, acc);
      apply(1, 0, 0, 0, 0, 0, acc);
      check("pre_flush_used", int'(bus.used_count), 9);
      apply(4, 4, 1, 0, 0, 0, acc);
      check("flush_acc", acc, 0);
      check("flush_used", int'(bus.used_count), 0);
      check("flush_head", int'(bus.ext_slot[0]), 0);
      check("flush_tail", int'(bus.ins_slot[0]), 0);

      // wrap: move head and tail to 14, then insert across the boundary
      apply(4, 0, 0, 0, 0, 0, acc);
      apply(4, 0, 0, 0, 0, 0, acc);
      apply(4, 0, 0, 0, 0, 0, acc);
      apply(2, 0, 0, 0, 0, 0, acc);
      apply(0, 4, 0, 0, 0, 0, acc);
      apply(0, 4, 0, 0, 0, 0, acc);
      apply(0, 4, 0, 0, 0, 0, acc);
      apply(0, 2, 0, 0, 0, 0, acc);
      check("wrap_slot0", int'(bus.ins_slot[0]), 14);
      check("wrap_slot1", int'(bus.ins_slot[1]), 15);
      check("wrap_slot2", int'(bus.ins_slot[2]), 0);
      check("wrap_slot3", int'(bus.ins_slot[3]), 1);
      apply(4, 0, 0, 0, 0, 0, acc);
      apply(0, 2, 0, 0, 0, 0, acc);

      // over-request with two live entries
      check("two_valid", int'(bus.ext_valid), 4'b0011);
      apply(0, 4, 0, 0, 0, 0, acc);
      check("drain_used", int'(bus.used_count), 0);
      check("drain_empty", int'(bus.empty), 1);
      check("drain_head", int'(bus.ext_slot[0]), 2);

      // partial flush: head=3, used=8
      apply(0, 0, 1, 0, 0, 0, acc);
      apply(4, 0, 0, 0, 0, 0, acc);
      apply(0, 3, 0, 0, 0, 0, acc);
      apply(4, 0, 0, 0, 0, 0, acc);
      apply(3, 0, 0, 0, 0, 0, acc);
      check("pf_setup_head", int'(bus.ext_slot[0]), 3);
      check("pf_setup_used", int'(bus.used_count), 8);
      apply(4, 2, 0, 1, 7, 0, acc);
      check("pf_acc", acc, 0);
      check("pf_tail", int'(bus.ins_slot[0]), 7);
      check("pf_used", int'(bus.used_count), 2);
      check("pf_head", int'(bus.ext_slot[0]), 5);
      apply(0, 0, 0, 1, 12, 0, acc);
      check("pf_ign_used", int'(bus.used_count), 2);
      check("pf_ign_tail", int'(bus.ins_slot[0]), 7);
      apply(4, 0, 0, 0, 0, 0, acc);
      apply(0, 3, 0, 1, 6, 0, acc);
      check("pf_over_head", int'(bus.ext_slot[0]), 8);
      check("pf_over_tail", int'(bus.ins_slot[0]), 8);
      check("pf_over_used", int'(bus.used_count), 0);

      // reset wins over flush and inserts in the same cycle
      apply(4, 0, 0, 0, 0, 0, acc);
      apply(4, 2, 1, 0, 0, 1, acc);
      check("rst2_used", int'(bus.used_count), 0);
      check("rst2_free", int'(bus.free_count), DEPTH);
      check("rst2_valid", int'(bus.ext_valid), 0);
      check("rst2_tail", int'(bus.ins_slot[0]), 0);
      apply(0, 0, 0, 0, 0, 0, acc);
      check("rst2_acc", acc, 0);

      // random traffic against the model
      for (int k = 0; k < 200; k++) begin
         bit fl, pf;
         fl = ($urandom_range(0, 31) == 0);
         pf = !fl && ($urandom_range(0, 9) == 0);
         apply($urandom_range(0, INS), $urandom_range(0, EXT), fl, pf,
               $urandom_range(0, DEPTH - 1), 0, acc);
      end

      @(negedge clock);
      bus.ins_count = '0;
      bus.ext_count = '0;
      bus.flush     = 1'b0;
      bus.pflush    = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
